// File: rtl/demod_pkg.sv
// Shared types for the demodulator lock supervisor: state encodings, loop-gain codes
// and the saturating phase-error magnitude helper.
package demod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_LOST   = 3'd4
  } state_t;

  localparam logic [1:0] GAIN_WIDE   = 2'd2;
  localparam logic [1:0] GAIN_MED    = 2'd1;
  localparam logic [1:0] GAIN_NARROW = 2'd0;

  // -32768 has no positive twin in 16 bits, so it clamps to 32767.
  function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
    if (x == 16'sh8000)
      return 16'h7FFF;
    else if (x < 0)
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

  function automatic logic [1:0] gain_for(input state_t s);
    case (s)
      ST_TRACK:  return GAIN_MED;
      ST_LOCKED: return GAIN_NARROW;
      default:   return GAIN_WIDE;
    endcase
  endfunction

endpackage

// File: rtl/demod_lock_ctrl_if.sv
// Signal bundle between the demodulator datapath (master) and the lock supervisor (slave).
interface demod_lock_ctrl_if;
  logic               enable;
  logic signed [15:0] phase_error;
  logic               sync_flag;
  logic               header_flag;
  logic               valid_flag;
  logic [1:0]         gain_sel;
  logic               resync;
  logic               locked;
  logic [2:0]         state_o;
  logic [15:0]        frame_cnt;
  logic [15:0]        err_cnt;

  modport master (
    output enable, phase_error, sync_flag, header_flag, valid_flag,
    input  gain_sel, resync, locked, state_o, frame_cnt, err_cnt
  );

  modport slave (
    input  enable, phase_error, sync_flag, header_flag, valid_flag,
    output gain_sel, resync, locked, state_o, frame_cnt, err_cnt
  );
endinterface

// File: rtl/sym_run_counter.sv
// Saturating run-length counter; o_hit flags the increment that reaches LIMIT,
// independent of i_clr so the controller can clear in response to it.
module sym_run_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam logic [WIDTH-1:0] LIM    = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_inc && (r_count < LIM))
      r_count <= r_count + WIDTH'(1);
  end

  assign o_hit = i_inc && (r_count >= LIM_M1);

endmodule

// File: rtl/demod_lock_ctrl.sv
// QPSK receive-chain lock supervisor: loop-gain selection, resync pulses, lock status.
// Define LOCK_STATS_EN to build the saturating good/bad frame statistics counters.
module demod_lock_ctrl
  import demod_pkg::*;
#(
  parameter logic [15:0] PE_THRESH     = 16'd2048,
  parameter int          LOCK_SYMS     = 64,
  parameter int          MISS_SYMS     = 16,
  parameter int          ACQ_TIMEOUT   = 4096,
  parameter int          FRAME_TIMEOUT = 1024,
  parameter int          MISS_FRAMES   = 3
) (
  input logic              clk,
  input logic              rst,
  demod_lock_ctrl_if.slave ctrl
);

  state_t     r_state, w_next;
  logic [1:0] r_gain;
  logic       r_resync, r_locked;
  logic       w_sym, w_in_lock, w_bad, w_resync, w_clr_all, w_acq_restart;
  logic       w_st_acq, w_st_track, w_st_locked;
  logic       w_lock_inc, w_lock_clr, w_lock_hit;
  logic       w_acq_inc, w_acq_hit;
  logic       w_miss_inc, w_miss_clr, w_miss_hit;
  logic       w_wd_inc, w_wd_clr, w_wd_hit;
  logic       w_bad_inc, w_bad_clr, w_bad_hit;

  assign w_sym       = ctrl.sync_flag;
  assign w_in_lock   = abs_sat(ctrl.phase_error) < PE_THRESH;
  assign w_bad       = ctrl.header_flag && !ctrl.valid_flag;
  assign w_st_acq    = (r_state == ST_ACQ);
  assign w_st_track  = (r_state == ST_TRACK);
  assign w_st_locked = (r_state == ST_LOCKED);

  // Increment/clear sources depend only on state and inputs, keeping hit -> clear acyclic.
  assign w_lock_inc = w_st_acq && w_sym && w_in_lock;
  assign w_lock_clr = w_st_acq && w_sym && !w_in_lock;
  assign w_acq_inc  = w_st_acq && w_sym;
  assign w_miss_inc = w_st_track && w_sym && !w_in_lock;
  assign w_miss_clr = w_st_track && w_sym && w_in_lock;
  assign w_wd_inc   = (w_st_track || w_st_locked) && w_sym;
  assign w_wd_clr   = (w_st_track && ctrl.header_flag) || (w_st_locked && ctrl.valid_flag);
  assign w_bad_inc  = w_st_locked && w_bad;
  assign w_bad_clr  = w_st_locked && ctrl.valid_flag;

  sym_run_counter #(.WIDTH(16), .LIMIT(LOCK_SYMS)) u_lock_run (
    .clk(clk), .rst(rst), .i_inc(w_lock_inc),
    .i_clr(w_lock_clr || w_clr_all || w_acq_restart), .o_hit(w_lock_hit)
  );
  sym_run_counter #(.WIDTH(16), .LIMIT(ACQ_TIMEOUT)) u_acq_timer (
    .clk(clk), .rst(rst), .i_inc(w_acq_inc),
    .i_clr(w_clr_all || w_acq_restart), .o_hit(w_acq_hit)
  );
  sym_run_counter #(.WIDTH(16), .LIMIT(MISS_SYMS)) u_miss_run (
    .clk(clk), .rst(rst), .i_inc(w_miss_inc),
    .i_clr(w_miss_clr || w_clr_all), .o_hit(w_miss_hit)
  );
  sym_run_counter #(.WIDTH(16), .LIMIT(FRAME_TIMEOUT)) u_frame_wd (
    .clk(clk), .rst(rst), .i_inc(w_wd_inc),
    .i_clr(w_wd_clr || w_clr_all), .o_hit(w_wd_hit)
  );
  sym_run_counter #(.WIDTH(16), .LIMIT(MISS_FRAMES)) u_bad_run (
    .clk(clk), .rst(rst), .i_inc(w_bad_inc),
    .i_clr(w_bad_clr || w_clr_all), .o_hit(w_bad_hit)
  );

  always_comb begin
    w_next        = r_state;
    w_resync      = 1'b0;
    w_clr_all     = 1'b0;
    w_acq_restart = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clr_all = 1'b1;
        w_next    = ST_ACQ;
      end
      ST_ACQ: begin
        if (w_lock_hit) begin
          w_next    = ST_TRACK;
          w_clr_all = 1'b1;
        end else if (w_acq_hit) begin
          w_resync      = 1'b1;
          w_acq_restart = 1'b1;
        end
      end
      ST_TRACK: begin
        if (ctrl.valid_flag) begin
          w_next    = ST_LOCKED;
          w_clr_all = 1'b1;
        end else if (w_wd_hit && !ctrl.header_flag) begin
          w_next    = ST_ACQ;
          w_resync  = 1'b1;
          w_clr_all = 1'b1;
        end else if (w_miss_hit) begin
          w_next    = ST_ACQ;
          w_clr_all = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!ctrl.valid_flag && (w_bad_hit || w_wd_hit)) begin
          w_next    = ST_LOST;
          w_resync  = 1'b1;
          w_clr_all = 1'b1;
        end
      end
      default: begin
        w_next    = ST_ACQ;
        w_clr_all = 1'b1;
      end
    endcase
    // Dropping enable overrides everything except reset and never pulses resync.
    if (!ctrl.enable) begin
      w_next        = ST_IDLE;
      w_resync      = 1'b0;
      w_clr_all     = 1'b1;
      w_acq_restart = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gain   <= GAIN_WIDE;
      r_resync <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_gain   <= gain_for(w_next);
      r_resync <= w_resync;
      r_locked <= (w_next == ST_LOCKED);
    end
  end

  assign ctrl.state_o  = r_state;
  assign ctrl.gain_sel = r_gain;
  assign ctrl.resync   = r_resync;
  assign ctrl.locked   = r_locked;

`ifdef LOCK_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;

  // Resync is counted during its pulse cycle, when the state is never LOCKED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_st_locked && ctrl.valid_flag && (r_frame_cnt != 16'hFFFF))
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (((w_st_locked && w_bad) || r_resync) && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign ctrl.frame_cnt = r_frame_cnt;
  assign ctrl.err_cnt   = r_err_cnt;
`else
  assign ctrl.frame_cnt = '0;
  assign ctrl.err_cnt   = '0;
`endif

endmodule

// File: tb/tb_demod_lock_ctrl.sv
// Self-checking bench for demod_lock_ctrl: directed lock scenarios plus randomized
// traffic, compared every cycle against a symbol-level behavioural model.
module tb_demod_lock_ctrl;

  localparam int LS = 4, MS = 2, AT = 8, FT = 6, MF = 2, PT = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demod_lock_ctrl_if bus();

  demod_lock_ctrl #(
    .PE_THRESH(16'd2048), .LOCK_SYMS(LS), .MISS_SYMS(MS),
    .ACQ_TIMEOUT(AT), .FRAME_TIMEOUT(FT), .MISS_FRAMES(MF)
  ) dut (
    .clk(clk), .rst(rst), .ctrl(bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state: 0 idle, 1 acquiring, 2 tracking, 3 locked, 4 lost.
  int m_state = 0, m_lock = 0, m_miss = 0, m_acq = 0, m_wd = 0, m_bad = 0;
  int m_frame = 0, m_err = 0;
  bit m_resync = 1'b0;

  function automatic int exp_gain(input int s);
    if (s == 2) return 1;
    if (s == 3) return 0;
    return 2;
  endfunction

  function automatic bit in_lock(input logic [15:0] pe);
    int p;
    p = int'($signed(pe));
    if (p < 0) p = -p;
    if (p > 32767) p = 32767;
    return p < PT;
  endfunction

  task automatic clear_runs();
    m_lock = 0; m_miss = 0; m_acq = 0; m_wd = 0; m_bad = 0;
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int ns;
    bit rs;
    bit il;
    bit bad_fr;
    if (rst) begin
      m_state = 0; clear_runs(); m_resync = 1'b0; m_frame = 0; m_err = 0;
    end else begin
      il     = in_lock(bus.phase_error);
      bad_fr = (m_state == 3) && bus.header_flag && !bus.valid_flag;
      if (m_state == 3 && bus.valid_flag && m_frame < 65535) m_frame++;
      m_err = m_err + int'(bad_fr) + int'(m_resync);
      if (m_err > 65535) m_err = 65535;
      ns = m_state;
      rs = 1'b0;
      if (!bus.enable) begin
        ns = 0; clear_runs();
      end else begin
        case (m_state)
          0: begin ns = 1; clear_runs(); end
          1: begin
            if (bus.sync_flag) begin m_acq++; m_lock = il ? m_lock + 1 : 0; end
            if (m_lock == LS) begin ns = 2; clear_runs(); end
            else if (m_acq == AT) begin rs = 1'b1; m_acq = 0; m_lock = 0; end
          end
          2: begin
            if (bus.sync_flag) begin m_wd++; m_miss = il ? 0 : m_miss + 1; end
            if (bus.header_flag) m_wd = 0;
            if (bus.valid_flag) begin ns = 3; clear_runs(); end
            else if (m_wd == FT) begin ns = 1; rs = 1'b1; clear_runs(); end
            else if (m_miss == MS) begin ns = 1; clear_runs(); end
          end
          3: begin
            if (bus.sync_flag) m_wd++;
            if (bus.valid_flag) begin m_wd = 0; m_bad = 0; end
            else if (bus.header_flag) m_bad++;
            if (!bus.valid_flag && (m_bad == MF || m_wd == FT)) begin
              ns = 4; rs = 1'b1; clear_runs();
            end
          end
          default: begin ns = 1; clear_runs(); end
        endcase
      end
      m_state  = ns;
      m_resync = rs;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state_o", int'(bus.state_o), m_state);
      cmp("gain_sel", int'(bus.gain_sel), exp_gain(m_state));
      cmp("resync", int'(bus.resync), int'(m_resync));
      cmp("locked", int'(bus.locked), int'(m_state == 3));
`ifdef LOCK_STATS_EN
      cmp("frame_cnt", int'(bus.frame_cnt), m_frame);
      cmp("err_cnt", int'(bus.err_cnt), m_err);
`else
      cmp("frame_cnt", int'(bus.frame_cnt), 0);
      cmp("err_cnt", int'(bus.err_cnt), 0);
`endif
    end
  end

  task automatic tick(input logic s, input logic [15:0] pe, input logic h, input logic v);
    bus.sync_flag   = s;
    bus.phase_error = pe;
    bus.header_flag = h;
    bus.valid_flag  = v;
    @(posedge clk);
    #1;
    bus.sync_flag   = 1'b0;
    bus.header_flag = 1'b0;
    bus.valid_flag  = 1'b0;
  endtask

  task automatic lit(input string nm, input int st, input int rs);
    cmp({nm, "_state"}, int'(bus.state_o), st);
    cmp({nm, "_resync"}, int'(bus.resync), rs);
  endtask

  initial begin
    logic [15:0] pe;
    bus.enable = 1'b0; bus.phase_error = '0;
    bus.sync_flag = 1'b0; bus.header_flag = 1'b0; bus.valid_flag = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit("reset", 0, 0);
    cmp("reset_gain", int'(bus.gain_sel), 2);
    cmp("reset_locked", int'(bus.locked), 0);
    rst = 1'b0;
    tick(0, 16'd0, 0, 0);
    lit("idle_hold", 0, 0);

    // Acquisition
    bus.enable = 1'b1;
    tick(0, 16'd0, 0, 0);
    lit("enter_acq", 1, 0);
    repeat (3) tick(1, 16'd100, 0, 0);
    lit("acq_3syms", 1, 0);
    tick(1, 16'd100, 0, 0);
    lit("acq_to_track", 2, 0);
    cmp("track_gain", int'(bus.gain_sel), 1);

    // Frame lock then loss by checksum
    tick(0, 16'd0, 0, 1);
    lit("frame_lock", 3, 0);
    cmp("lock_flag", int'(bus.locked), 1);
    cmp("lock_gain", int'(bus.gain_sel), 0);
    tick(0, 16'd0, 1, 0);
    lit("bad_frame1", 3, 0);
    tick(0, 16'd0, 1, 0);
    lit("bad_frame2_lost", 4, 1);
    tick(0, 16'd0, 0, 0);
    lit("lost_to_acq", 1, 0);
`ifdef LOCK_STATS_EN
    cmp("err_after_loss", int'(bus.err_cnt), 3);
    cmp("frame_after_loss", int'(bus.frame_cnt), 0);
`endif

    // ACQ timeout
    repeat (7) tick(1, 16'h8000, 0, 0);
    lit("acq_7syms", 1, 0);
    tick(1, 16'h8000, 0, 0);
    lit("acq_timeout", 1, 1);
    tick(0, 16'd0, 0, 0);
    lit("acq_after_timeout", 1, 0);

    // Threshold boundaries; lock completes on the same symbol as the timer
    tick(1, 16'd2047, 0, 0);
    tick(1, 16'd2048, 0, 0);
    tick(1, 16'hF801, 0, 0);
    tick(1, 16'hF800, 0, 0);
    tick(1, 16'd2047, 0, 0);
    tick(1, 16'hF801, 0, 0);
    tick(1, 16'd2047, 0, 0);
    lit("boundary_3run", 1, 0);
    tick(1, 16'hF801, 0, 0);
    lit("boundary_lock", 2, 0);

    // Miss run in TRACK
    tick(1, 16'h8000, 0, 0);
    lit("miss1", 2, 0);
    tick(1, 16'h8000, 0, 0);
    lit("miss2_to_acq", 1, 0);

    // Frame watchdog in TRACK
    repeat (4) tick(1, 16'd100, 0, 0);
    lit("retrack", 2, 0);
    repeat (5) tick(1, 16'd100, 0, 0);
    lit("track_wd5", 2, 0);
    tick(1, 16'd100, 0, 0);
    lit("track_wd_expire", 1, 1);

    // Watchdog vs valid in LOCKED
    tick(0, 16'd0, 0, 0);
    repeat (4) tick(1, 16'd100, 0, 0);
    tick(0, 16'd0, 0, 1);
    lit("relock", 3, 0);
    repeat (5) tick(1, 16'd100, 0, 0);
    tick(1, 16'd100, 0, 1);
    lit("valid_saves", 3, 0);
    repeat (5) tick(1, 16'd100, 0, 0);
    lit("locked_wd5", 3, 0);
    tick(1, 16'd100, 0, 0);
    lit("locked_wd_lost", 4, 1);
    tick(0, 16'd0, 0, 0);
    lit("lost_exit", 1, 0);

    // Abort by enable, then by reset while locked
    repeat (2) tick(1, 16'd100, 0, 0);
    bus.enable = 1'b0;
    tick(0, 16'd0, 0, 0);
    lit("enable_abort", 0, 0);
    cmp("abort_gain", int'(bus.gain_sel), 2);
    bus.enable = 1'b1;
    tick(0, 16'd0, 0, 0);
    repeat (4) tick(1, 16'd100, 0, 0);
    tick(0, 16'd0, 0, 1);
    lit("lock_before_rst", 3, 0);
    #2 rst = 1'b1;
    #1;
    lit("async_rst", 0, 0);
    cmp("rst_gain", int'(bus.gain_sel), 2);
    cmp("rst_locked", int'(bus.locked), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.enable = ($urandom_range(0, 63) != 0);
      case ($urandom_range(0, 7))
        0: pe = 16'h8000;
        1: pe = 16'($urandom);
        2: case ($urandom_range(0, 3))
             0: pe = 16'd2047;
             1: pe = 16'd2048;
             2: pe = 16'hF800;
             default: pe = 16'hF801;
           endcase
        default: begin
          pe = 16'($urandom_range(0, 1500));
          if ($urandom_range(0, 1) == 1) pe = -pe;
        end
      endcase
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        tick(0, 16'd0, 0, 0);
        rst = 1'b0;
      end else begin
        tick(1'($urandom_range(0, 1)), pe, ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 19) == 0));
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demod_lock_ctrl.md
Name: demod_lock_ctrl

Overview:
- Supervisory FSM for the QPSK demodulator receive chain, in the 500 kHz sample-clock domain.
- Monitors the phase-detector error, the Gardner symbol strobe and the frame header/checksum flags.
- Selects the carrier-loop gain, issues resync pulses to the timing and framing stages, and reports lock status.
- Sits beside the demodulator top level; its outputs drive loop-gain muxing and the resync of the bit-sync and framing blocks.

Parameters:
- PE_THRESH, 16'd2048: magnitude limit on phase_error for an "in-lock" symbol.
- LOCK_SYMS, 64: consecutive in-lock symbols required to leave ACQ.
- MISS_SYMS, 16: consecutive out-of-lock symbols in TRACK that force a return to ACQ.
- ACQ_TIMEOUT, 4096: symbols allowed in ACQ before a resync pulse.
- FRAME_TIMEOUT, 1024: symbols allowed without header_flag (TRACK) or valid_flag (LOCKED).
- MISS_FRAMES, 3: consecutive bad-checksum frames in LOCKED that cause LOST.

Ports:
- clk  in  1: 500 kHz sample clock.
- rst  in  1: asynchronous, active-high reset.
- enable  in  1: run request; low forces IDLE.
- phase_error  in  16: signed phase-detector output.
- sync_flag  in  1: one-cycle pulse per symbol decision.
- header_flag  in  1: one-cycle pulse, frame header detected.
- valid_flag  in  1: one-cycle pulse, header and checksum correct.
- gain_sel  out  2: 2 = wide (acquire), 1 = medium, 0 = narrow.
- resync  out  1: one-cycle pulse requesting reset of timing/framing.
- locked  out  1: high only in LOCKED.
- state_o  out  3: current state encoding.
- frame_cnt  out  16: good-frame counter (optional).
- err_cnt  out  16: bad-frame counter (optional).

Behaviour:
- Reset values: all outputs 0 except gain_sel = 2; state = IDLE; all counters 0.
- Asynchronous assertion of rst takes effect immediately; internal and output state is re-established on the first edge after deassertion.
- All outputs are registered.
- States and encodings: IDLE = 0, ACQ = 1, TRACK = 2, LOCKED = 3, LOST = 4.
- gain_sel per state: IDLE 2, ACQ 2, TRACK 1, LOCKED 0, LOST 2.
- |pe| definition: two's-complement absolute value; -32768 saturates to 32767.
- in-lock symbol: |pe| < PE_THRESH, sampled only on cycles where sync_flag = 1.
- All symbol counters advance only on sync_flag.
- IDLE -> ACQ when enable = 1; all counters are cleared on entry.
- ACQ:
  - lock_run increments on each in-lock symbol and clears on each out-of-lock symbol.
  - lock_run reaching LOCK_SYMS -> TRACK.
  - acq_timer reaching ACQ_TIMEOUT -> resync pulse for 1 cycle, clear acq_timer and lock_run, remain in ACQ.
- TRACK:
  - miss_run counts consecutive out-of-lock symbols; miss_run = MISS_SYMS -> ACQ.
  - valid_flag -> LOCKED.
  - frame watchdog reaching FRAME_TIMEOUT without header_flag -> ACQ, with resync pulse.
- LOCKED:
  - valid_flag clears the watchdog and bad_run.
  - header_flag without valid_flag in the same cycle increments bad_run.
  - bad_run = MISS_FRAMES -> LOST.
  - watchdog expiry (no valid_flag for FRAME_TIMEOUT symbols) -> LOST.
- LOST: single cycle; resync = 1; next state ACQ.
- Priority, highest first: rst, then enable = 0 (-> IDLE from any state, no resync), then valid_flag, then timeouts/miss limits.
- header_flag and valid_flag in the same cycle count as a good frame.
- Latency: a state change is visible on state_o, gain_sel and locked one clock after the qualifying input cycle.

Optional Feature:
- LOCK_STATS_EN defined:
  - frame_cnt increments on each valid_flag in LOCKED.
  - err_cnt increments on each bad frame in LOCKED and on each resync pulse.
  - Both counters saturate at 16'hFFFF and clear only on rst.
- LOCK_STATS_EN undefined: frame_cnt and err_cnt are tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package demod_pkg holds:
  - state typedef and encodings;
  - gain_sel constants GAIN_WIDE, GAIN_MED, GAIN_NARROW;
  - the abs-saturate function.
- One sub-module, sym_run_counter: a saturating run-length counter with inc, clr and limit-hit output. It is instantiated for lock_run, miss_run, acq_timer, the frame watchdog and bad_run.

Test Plan (all scenarios use LOCK_SYMS = 4, MISS_SYMS = 2, ACQ_TIMEOUT = 8, FRAME_TIMEOUT = 6, MISS_FRAMES = 2):
1. Acquisition: rst, then enable = 1, then 4 sync_flag pulses with phase_error = 100 -> state_o 1 -> 2 one cycle after the 4th pulse; gain_sel 2 -> 1.
2. ACQ timeout: 8 symbols with phase_error = 16'h8000 -> exactly one resync pulse after the 8th symbol; state_o stays 1.
3. Frame lock: in TRACK, one valid_flag pulse -> locked = 1 and gain_sel = 0 the next cycle.
4. Loss by checksum: in LOCKED, two header_flag pulses without valid_flag -> LOST for 1 cycle with resync = 1, then ACQ; with LOCK_STATS_EN, err_cnt = 3 (2 bad frames + 1 resync).
5. Watchdog vs valid: in LOCKED, valid_flag arrives in the same cycle as the 6th symbol -> stays LOCKED; with no valid_flag for 6 symbols -> LOST.
6. Abort: enable dropped mid-ACQ, and separately rst asserted mid-LOCKED -> IDLE with gain_sel = 2 and no resync pulse.
